// File: rtl/fifo_write_arbiter.sv
// Two-requester write arbiter in front of a single FIFO write port.
// A requester owns the port for a tenure of up to BURST_MAX writes. A tenure
// ends early when its requester drops valid. A round-robin pointer decides
// contested grants. Words pass through combinationally, so an accepted word
// is written on the same edge as its handshake.
module fifo_write_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              fifo_full,
  output logic              write_e,
  output logic [DATA_W-1:0] data_in,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  // Count value at which the current fire is the last one of the tenure.
  localparam logic [2:0] LAST_CNT = 3'(BURST_MAX - 1);

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [2:0]  burst_cnt_q, burst_cnt_d;
  logic [1:0]  grant_q;

  logic        active_s;
  logic        cur_valid_s;
  logic        other_valid_s;
  logic [DATA_W-1:0] cur_data_s;
  logic        fire_s;
  logic        release_s;

  // One-hot owner code for a state.
  function automatic logic [1:0] grant_of(input state_t st);
    case (st)
      G0:      grant_of = 2'b01;
      G1:      grant_of = 2'b10;
      default: grant_of = 2'b00;
    endcase
  endfunction

  // Select the owning requester's signals and qualify the handshake.
  always_comb begin
    cur_valid_s   = 1'b0;
    other_valid_s = 1'b0;
    cur_data_s    = {DATA_W{1'b0}};
    case (state_q)
      G0: begin
        cur_valid_s   = req0_valid;
        other_valid_s = req1_valid;
        cur_data_s    = req0_data;
      end
      G1: begin
        cur_valid_s   = req1_valid;
        other_valid_s = req0_valid;
        cur_data_s    = req1_data;
      end
      default: begin
        cur_valid_s   = 1'b0;
        other_valid_s = 1'b0;
        cur_data_s    = {DATA_W{1'b0}};
      end
    endcase
    // Reset masks every handshake so nothing is accepted while it is held.
    active_s  = (state_q != IDLE) && !reset;
    fire_s    = active_s && cur_valid_s && !fifo_full;
    release_s = active_s && (!cur_valid_s || (fire_s && (burst_cnt_q == LAST_CNT)));
  end

  // Drive the zero-latency handshake and FIFO write port.
  always_comb begin
    req0_ready = !reset && (state_q == G0) && !fifo_full;
    req1_ready = !reset && (state_q == G1) && !fifo_full;
    write_e    = fire_s;
    if (fire_s) begin
      data_in = cur_data_s;
    end else begin
      data_in = {DATA_W{1'b0}};
    end
  end

  // Next-state, round-robin pointer and burst counter logic.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        burst_cnt_d = 3'd0;
        if (req0_valid && req1_valid) begin
          state_d = prio_q ? G1 : G0;
        end else if (req0_valid) begin
          state_d = G0;
        end else if (req1_valid) begin
          state_d = G1;
        end else begin
          state_d = IDLE;
        end
      end
      G0, G1: begin
        if (release_s) begin
          burst_cnt_d = 3'd0;
          prio_d      = (state_q == G0) ? 1'b1 : 1'b0;
          if (other_valid_s) begin
            state_d = (state_q == G0) ? G1 : G0;
          end else begin
            state_d = IDLE;
          end
        end else if (fire_s) begin
          burst_cnt_d = burst_cnt_q + 3'd1;
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        prio_d      = 1'b0;
        burst_cnt_d = 3'd0;
      end
    endcase
  end

  // Arbiter state register; grant is registered alongside the state it decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      burst_cnt_q <= 3'd0;
      grant_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      burst_cnt_q <= burst_cnt_d;
      grant_q     <= grant_of(state_d);
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized bench for fifo_write_arbiter.
module tb_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, fifo_full = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, write_e;
  logic [7:0] data_in;
  logic [1:0] grant;

  // Second instance with single-write tenures, both requesters always valid.
  logic       u1_v0 = 1'b1, u1_v1 = 1'b1, u1_full = 1'b0;
  logic [7:0] u1_d0 = 8'h5A, u1_d1 = 8'hC3;
  logic       u1_r0, u1_r1, u1_we;
  logic [7:0] u1_din;
  logic [1:0] u1_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.DATA_W(8), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_full(fifo_full), .write_e(write_e), .data_in(data_in), .grant(grant)
  );

  fifo_write_arbiter #(.DATA_W(8), .BURST_MAX(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(u1_v0), .req0_data(u1_d0), .req0_ready(u1_r0),
    .req1_valid(u1_v1), .req1_data(u1_d1), .req1_ready(u1_r1),
    .fifo_full(u1_full), .write_e(u1_we), .data_in(u1_din), .grant(u1_grant)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       full;
    logic [1:0] g;
    logic       r0;
    logic       r1;
    logic       we;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[33];

  function automatic vec_t mk(input logic rst, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1, input logic full,
                              input logic [1:0] g, input logic r0, input logic r1,
                              input logic we, input logic [7:0] dout);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.full = full;
    v.g = g; v.r0 = r0; v.r1 = r1; v.we = we; v.dout = dout;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; fifo_full = 1'b0;
    #1;
    check("rst_outputs_low", {29'd0, write_e, req0_ready, req1_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_outputs_low2", {29'd0, write_e, req0_ready, req1_ready}, 32'd0);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_order[12];
    int n0, n1, k, run;
    logic [1:0] prev_g;
    logic [6:0] s0, s1;
    logic hs0, hs1, exp_we;

    //              rst v0  d0    v1  d1    full g      r0  r1  we  dout
    // Basic burst of four, release to IDLE, second tenure.
    tbl[0]  = mk(1'b0,1'b1,8'h01,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,8'h00);
    tbl[1]  = mk(1'b0,1'b1,8'h01,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h01);
    tbl[2]  = mk(1'b0,1'b1,8'h09,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h09);
    tbl[3]  = mk(1'b0,1'b1,8'h07,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h07);
    tbl[4]  = mk(1'b0,1'b1,8'h03,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h03);
    tbl[5]  = mk(1'b0,1'b1,8'h04,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,8'h00);
    tbl[6]  = mk(1'b0,1'b1,8'h04,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h04);
    tbl[7]  = mk(1'b0,1'b1,8'h06,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h06);
    tbl[8]  = mk(1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b0,8'h00);
    tbl[9]  = mk(1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,8'h00);
    // FIFO full for three cycles mid-burst.
    tbl[10] = mk(1'b0,1'b1,8'h11,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,8'h00);
    tbl[11] = mk(1'b0,1'b1,8'h11,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h11);
    tbl[12] = mk(1'b0,1'b1,8'h12,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h12);
    tbl[13] = mk(1'b0,1'b1,8'h13,1'b0,8'h00,1'b1,2'b01,1'b0,1'b0,1'b0,8'h00);
    tbl[14] = mk(1'b0,1'b1,8'h13,1'b0,8'h00,1'b1,2'b01,1'b0,1'b0,1'b0,8'h00);
    tbl[15] = mk(1'b0,1'b1,8'h13,1'b0,8'h00,1'b1,2'b01,1'b0,1'b0,1'b0,8'h00);
    tbl[16] = mk(1'b0,1'b1,8'h13,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h13);
    tbl[17] = mk(1'b0,1'b1,8'h14,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h14);
    tbl[18] = mk(1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,8'h00);
    // Pointer now favours requester 1; it drops valid after one write.
    tbl[19] = mk(1'b0,1'b1,8'h21,1'b1,8'h31,1'b0,2'b00,1'b0,1'b0,1'b0,8'h00);
    tbl[20] = mk(1'b0,1'b1,8'h21,1'b1,8'h31,1'b0,2'b10,1'b0,1'b1,1'b1,8'h31);
    tbl[21] = mk(1'b0,1'b1,8'h21,1'b0,8'h00,1'b0,2'b10,1'b0,1'b1,1'b0,8'h00);
    // Full four-write tenure in G0 proves the counter was cleared.
    tbl[22] = mk(1'b0,1'b1,8'h21,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h21);
    tbl[23] = mk(1'b0,1'b1,8'h22,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h22);
    tbl[24] = mk(1'b0,1'b1,8'h23,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h23);
    tbl[25] = mk(1'b0,1'b1,8'h24,1'b0,8'h00,1'b0,2'b01,1'b1,1'b0,1'b1,8'h24);
    tbl[26] = mk(1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,2'b00,1'b0,1'b0,1'b0,8'h00);
    // Reset during G1 after two writes; the pending word stays put.
    tbl[27] = mk(1'b0,1'b0,8'h00,1'b1,8'h41,1'b0,2'b00,1'b0,1'b0,1'b0,8'h00);
    tbl[28] = mk(1'b0,1'b0,8'h00,1'b1,8'h41,1'b0,2'b10,1'b0,1'b1,1'b1,8'h41);
    tbl[29] = mk(1'b0,1'b0,8'h00,1'b1,8'h42,1'b0,2'b10,1'b0,1'b1,1'b1,8'h42);
    tbl[30] = mk(1'b1,1'b0,8'h00,1'b1,8'h43,1'b0,2'b10,1'b0,1'b0,1'b0,8'h00);
    tbl[31] = mk(1'b0,1'b1,8'h51,1'b1,8'h43,1'b0,2'b00,1'b0,1'b0,1'b0,8'h00);
    tbl[32] = mk(1'b0,1'b1,8'h51,1'b1,8'h43,1'b0,2'b01,1'b1,1'b0,1'b1,8'h51);

    do_reset();

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_data = tbl[i].d1;
      fifo_full = tbl[i].full;
      #1;
      check($sformatf("vec%0d", i),
            {19'd0, grant, req0_ready, req1_ready, write_e, data_in},
            {19'd0, tbl[i].g, tbl[i].r0, tbl[i].r1, tbl[i].we, tbl[i].dout});
    end

    // Both requesters valid continuously: A0-A3, B0-B3, A4-A7, no idle gap.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_order[i]     = 8'hA0 + 8'(i);
      exp_order[i + 4] = 8'hB0 + 8'(i);
      exp_order[i + 8] = 8'hA4 + 8'(i);
    end
    n0 = 0; n1 = 0; k = 0;
    for (int cyc = 0; cyc < 40 && k < 12; cyc++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1; fifo_full = 1'b0;
      req0_data = 8'hA0 + 8'(n0);
      req1_data = 8'hB0 + 8'(n1);
      #1;
      if (k > 0) check("no_idle_gap", {31'd0, grant == 2'b00}, 32'd0);
      if (write_e) begin
        check($sformatf("order%0d", k), {24'd0, data_in}, {24'd0, exp_order[k]});
        k++;
      end
      if (req0_valid && req0_ready) n0++;
      if (req1_valid && req1_ready) n1++;
    end
    check("order_count", k, 32'd12);

    // Single-write tenures alternate between requesters.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("b1_cyc%0d", i), {21'd0, u1_grant, u1_we, u1_din},
            (i % 2 == 0) ? {21'd0, 2'b01, 1'b1, 8'h5A} : {21'd0, 2'b10, 1'b1, 8'hC3});
    end

    // Random valid/full traffic against a per-requester sequence model.
    do_reset();
    s0 = 7'd0; s1 = 7'd0; hs0 = 1'b0; hs1 = 1'b0; run = 0; prev_g = 2'b00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (hs0 || !req0_valid) req0_valid = 1'($urandom_range(0, 1));
      if (hs1 || !req1_valid) req1_valid = 1'($urandom_range(0, 1));
      req0_data = {1'b0, s0};
      req1_data = {1'b1, s1};
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      exp_we = ((grant == 2'b01) && req0_valid && !fifo_full) ||
               ((grant == 2'b10) && req1_valid && !fifo_full);
      check("rnd_ready", {30'd0, req0_ready, req1_ready},
            {30'd0, (grant == 2'b01) && !fifo_full, (grant == 2'b10) && !fifo_full});
      check("rnd_we", {31'd0, write_e}, {31'd0, exp_we});
      if (grant != prev_g) run = 0;
      prev_g = grant;
      if (exp_we) begin
        run++;
        check("rnd_data", {24'd0, data_in},
              {24'd0, (grant == 2'b01) ? {1'b0, s0} : {1'b1, s1}});
        check("rnd_burst_len", {31'd0, run > 4}, 32'd0);
      end
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (hs0) s0 = s0 + 7'd1;
      if (hs1) s1 = s1 + 7'd1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the width of the data path to the FIFO write port.
REQ-002 The block SHALL have parameter BURST_MAX, default 4, meaning the maximum writes per grant tenure (range 1..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req0_valid, input, 1 bit: requester 0 has a word to write.
REQ-006 The block SHALL have port req0_data, input, DATA_W bits: requester 0 write data.
REQ-007 The block SHALL have port req0_ready, output, 1 bit: requester 0 word accepted this cycle when high with req0_valid.
REQ-008 The block SHALL have ports req1_valid, req1_data and req1_ready, identical to requester 0 in direction and width.
REQ-009 The block SHALL have port fifo_full, input, 1 bit: full flag from the downstream FIFO.
REQ-010 The block SHALL have port write_e, output, 1 bit: FIFO write enable.
REQ-011 The block SHALL have port data_in, output, DATA_W bits: FIFO write data.
REQ-012 The block SHALL have port grant, output, 2 bits, one-hot: current owner, 00 when idle.

Function
REQ-013 The FSM SHALL have three states: IDLE, G0 and G1; grant SHALL be 00, 01 and 10 respectively, decoded from registered state.
REQ-014 IDLE: with exactly one valid asserted, the FSM SHALL go to that requester's state at the next edge; with neither asserted it SHALL stay in IDLE.
REQ-015 IDLE with both valid: the FSM SHALL go to the state selected by the priority pointer prio (0 selects G0, 1 selects G1).
REQ-016 In Gx: reqx_ready SHALL equal !fifo_full (combinational) and the other ready SHALL be 0.
REQ-017 In Gx: fire SHALL equal reqx_valid && !fifo_full, write_e SHALL equal fire, and data_in SHALL equal reqx_data when fire and 0 otherwise.
REQ-018 Write latency SHALL be zero cycles: the accepted word SHALL reach the FIFO on the same edge as the handshake.
REQ-019 A burst counter burst_cnt (3-bit) SHALL increment on each fire in Gx.
REQ-020 Gx SHALL release when fire occurs with burst_cnt == BURST_MAX-1, or when reqx_valid is 0.
REQ-021 On release from Gx: the next state SHALL be the other grant state if the other valid is high, else IDLE.
REQ-022 On release: burst_cnt SHALL clear to 0 and prio SHALL point to the other requester.
REQ-023 fifo_full high in Gx SHALL hold the grant with no write, no burst_cnt change and no release, provided reqx_valid stays high.
REQ-024 A requester SHALL hold valid and data stable until ready; the arbiter SHALL NOT drop or duplicate words.
REQ-025 In IDLE, write_e, req0_ready and req1_ready SHALL all be 0.
REQ-026 With BURST_MAX=1, each grant SHALL carry exactly one write, and both-valid traffic SHALL alternate 0,1,0,1.

Reset
REQ-027 While reset is high at an edge: state SHALL become IDLE, prio 0, burst_cnt 0, and grant 00.
REQ-028 During reset: write_e, req0_ready and req1_ready SHALL be 0 regardless of the inputs.
REQ-029 Reset asserted mid-burst SHALL abandon the tenure; the word not yet accepted SHALL remain pending at its requester.

Verification
REQ-030 Reset, then req0_valid=1 with data 01,09,07,03,04,06 (BURST_MAX=4) -> IDLE one cycle, then G0; writes 01,09,07,03; release to IDLE one cycle; G0 again; writes 04,06.
REQ-031 Both valid continuously from reset, req0 data A0.., req1 data B0.. -> FIFO order A0-A3, B0-B3, A4-A7; grant 01/10 alternating with no idle gap.
REQ-032 In G0 after 2 writes, fifo_full=1 for 3 cycles -> write_e=0 and req0_ready=0 for those cycles; grant stays 01; the burst then completes 2 more writes.
REQ-033 In G1, req1_valid drops after 1 write while req0_valid=1 -> the next edge moves to G0 and burst_cnt=0.
REQ-034 Reset pulsed during G1 after 2 writes -> next cycle grant=00 and prio=0; both then valid -> G0 granted first.
REQ-035 Scoreboard over random valid/full traffic -> FIFO receives every requester word exactly once, in per-requester order, with never more than BURST_MAX consecutive writes per grant.
